// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the iterative AES SubBytes/ShiftRows stage.
// The inverse-cipher path is compiled only when AES_INV_CIPHER_EN is defined.
package aes_pkg;

    localparam int NB = 4;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // FIPS-197 column-major byte numbering: byte i = s[r][c] with i = r + 4c
    function automatic int idx(input int r, input int c);
        return r + 4 * c;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 S-box lookup; aes_inv_sbox exists only when AES_INV_CIPHER_EN is defined.
// Each table is held MSB-first so entry 0 sits in the leftmost hex digits.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_out = SBOX[i_in];

endmodule

`ifdef AES_INV_CIPHER_EN
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign o_out = INV_SBOX[i_in];

endmodule
`endif

// File: rtl/aes_sub_shift.sv
// Iterative AES SubBytes + ShiftRows: four shared S-boxes, one output column per clock.
// Defining AES_INV_CIPHER_EN adds the inv port and the InvShiftRows + InvSubBytes path.
module aes_sub_shift
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef AES_INV_CIPHER_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (NB != aes_pkg::NB) begin : g_nb_check
        $error("aes_sub_shift: NB must be 4");
    end

    fsm_e        r_fsm;
    logic [1:0]  r_col;
    state_t      r_state;
    state_t      r_out_data;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_busy;
`ifdef AES_INV_CIPHER_EN
    logic        r_inv;
`endif

    logic [1:0]  w_src_col [4];
    byte_t       w_gather  [4];
    byte_t       w_fwd     [4];
    byte_t       w_sub     [4];

    // ShiftRows lives in the read address: row r of column c comes from column c+r (c-r inverse)
    always_comb begin
        for (int r = 0; r < 4; r++) begin
`ifdef AES_INV_CIPHER_EN
            w_src_col[r] = r_inv ? (r_col - 2'(r)) : (r_col + 2'(r));
`else
            w_src_col[r] = r_col + 2'(r);
`endif
            w_gather[r] = r_state[127 - 8 * idx(r, int'(w_src_col[r])) -: 8];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_in  (w_gather[g]),
            .o_out (w_fwd[g])
        );
`ifdef AES_INV_CIPHER_EN
        byte_t w_inv;
        aes_inv_sbox u_inv_sbox (
            .i_in  (w_gather[g]),
            .o_out (w_inv)
        );
        assign w_sub[g] = r_inv ? w_inv : w_fwd[g];
`else
        assign w_sub[g] = w_fwd[g];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_col       <= 2'd0;
            r_state     <= '0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef AES_INV_CIPHER_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state    <= in_data;
`ifdef AES_INV_CIPHER_EN
                        r_inv      <= inv;
`endif
                        r_col      <= 2'd0;
                        r_fsm      <= BUSY;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int r = 0; r < 4; r++) begin
                        r_out_data[127 - 8 * idx(r, int'(r_col)) -: 8] <= w_sub[r];
                    end
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_fsm       <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_sub_shift.sv
// Scoreboard bench for aes_sub_shift; the reference S-box is derived from GF(2^8) arithmetic.
// Inverse-mode cases are included when AES_INV_CIPHER_EN is defined.
module tb_aes_sub_shift;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         inv_drv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   m_sbox  [256];
    logic [7:0]   m_isbox [256];

    always #5 clk = ~clk;

    aes_sub_shift dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef AES_INV_CIPHER_EN
        .inv       (inv_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] w = {x, x} << n;
        return w[15:8];
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input logic inv_m);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                int         src;
                logic [7:0] b;
                src = inv_m ? ((c - r + 4) % 4) : ((c + r) % 4);
                b   = s[127 - 8 * (r + 4 * src) -: 8];
                o[127 - 8 * (r + 4 * c) -: 8] = inv_m ? m_isbox[b] : m_sbox[b];
            end
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic iv, input logic [127:0] exp);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) check("send_ready_timeout", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_data  = d;
        inv_drv  = iv;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
    endtask

    task automatic wait_drain(input int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            tick();
            k++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 128'(exp_q.size()), 128'd1);
            end else begin
                check("sb_out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        logic [127:0] e;
        int           k;

        for (int i = 0; i < 256; i++) begin
            logic [7:0] x;
            x = 8'h01;
            for (int j = 0; j < 254; j++) x = gmul(x, 8'(i));
            m_sbox[i] = x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
        end
        for (int i = 0; i < 256; i++) m_isbox[m_sbox[i]] = 8'(i);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        inv_drv   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  128'(in_ready),  128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        check("rst_out_data",  out_data,        128'd0);
        rst = 1'b0;

        // All-zero state: every output byte is S(0) = 0x63
        send(128'd0, 1'b0, {16{8'h63}});
        tick();
        check("zero_e1_valid", 128'(out_valid), 128'd0);
        tick();
        tick();
        check("zero_e3_valid", 128'(out_valid), 128'd0);
        tick();
        check("zero_e4_valid", 128'(out_valid), 128'd1);
        check("zero_e4_busy",  128'(busy),      128'd1);
        check("zero_e4_data",  out_data,        {16{8'h63}});
        out_ready = 1'b1;
        tick();
        check("zero_hs_in_ready",  128'(in_ready),  128'd1);
        check("zero_hs_out_valid", 128'(out_valid), 128'd0);

        // FIPS-197 Appendix B, round 1
        send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        tick();
        tick();
        tick();
        check("fips_e3_valid", 128'(out_valid), 128'd0);
        tick();
        check("fips_e4_valid", 128'(out_valid), 128'd1);
        wait_drain(5);

        // Backpressure with a competing in_valid during the stall
        out_ready = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        e = ref_model(d, 1'b0);
        send(d, 1'b0, e);
        k = 0;
        while (!out_valid && k < 10) begin
            tick();
            k++;
        end
        check("bp_valid_rise", 128'(out_valid), 128'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            check("bp_stall_valid",    128'(out_valid), 128'd1);
            check("bp_stall_data",     out_data,        e);
            check("bp_stall_in_ready", 128'(in_ready),  128'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready",  128'(in_ready),  128'd1);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);
        tick();
        check("bp_no_late_accept", 128'(busy), 128'd0);
        check("bp_scoreboard", 128'(exp_q.size()), 128'd0);

        // Reset while the column counter sits at 2
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 1'b0, ref_model(d, 1'b0));
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_in_ready",  128'(in_ready),  128'd1);
        check("midrst_busy",      128'(busy),      128'd0);
        check("midrst_out_data",  out_data,        128'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 1'b0, ref_model(d, 1'b0));
        wait_drain(10);

        // Back-to-back streaming with out_ready held high
        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send(d, 1'b0, ref_model(d, 1'b0));
        end
        wait_drain(20);

`ifdef AES_INV_CIPHER_EN
        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        wait_drain(10);
        send({16{8'hed}}, 1'b1, {16{8'h53}});
        wait_drain(10);
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 1'b1, ref_model(d, 1'b1));
        wait_drain(10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
